value_change_fifo: RTL and testbench

- Downstream consumer of the 8-bit free-running counter output.
- Samples the counter value every clock and detects changes.
- Each change is queued as a {value, timestamp} record in a small FIFO, drained over a valid/ready interface.
- This is the hardware equivalent of the bench-side "print on change" monitor, so counter activity is observable on-chip.

---
 rtl/value_change_fifo.sv | 59 +++++
 tb/tb_value_change_fifo.sv | 124 ++++++++++++
 2 files changed

// File: rtl/value_change_fifo.sv
// value_change_fifo: detects changes on a sampled value and queues {value, timestamp}
// records in a show-ahead FIFO drained over a valid/ready interface.
module value_change_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TS_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           value,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_value,
  output logic [TS_WIDTH-1:0]        out_time,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [7:0]                 drop_count
);
  localparam int AW = $clog2(DEPTH);
  logic [TS_WIDTH-1:0] ts;
  logic [WIDTH-1:0] prev;
  logic primed;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [WIDTH+TS_WIDTH-1:0] mem [DEPTH];
  logic change, full, pop, push, drop;
  // Pointers carry one extra bit so full and empty are distinguishable.
  always_comb begin
    level = wr_ptr - rd_ptr;
    full = level == (AW+1)'(DEPTH);
    out_valid = level != '0;
    pop = out_valid && out_ready;
    change = !primed || value != prev;
    push = change && (!full || pop);
    drop = change && full && !pop;
    out_value = out_valid ? mem[rd_ptr[AW-1:0]][WIDTH+TS_WIDTH-1:TS_WIDTH] : '0;
    out_time = out_valid ? mem[rd_ptr[AW-1:0]][TS_WIDTH-1:0] : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ts <= '0;
      prev <= '0;
      primed <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      ts <= ts + 1'b1;
      prev <= value;
      primed <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop) overflow <= 1'b1;
      if (drop && drop_count != 8'hff) drop_count <= drop_count + 8'd1;
    end
  // Storage is not reset; pointers alone define which entries are live.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {value, ts};
endmodule

// File: tb/tb_value_change_fifo.sv
// tb_value_change_fifo: randomized stimulus against a queue-based reference model;
// a second instance with TS_WIDTH=4 checks timestamp wrap.
module tb_value_change_fifo;
  logic clk = 1'b0, reset = 1'b1, out_ready = 1'b0;
  logic [7:0] value = 8'h00;
  logic out_valid, out_valid4, overflow, overflow4;
  logic [7:0] out_value, out_value4, drop_count, drop_count4;
  logic [15:0] out_time;
  logic [3:0] out_time4;
  logic [2:0] level, level4;
  int n_checks = 0, n_pass = 0;
  typedef struct {logic [7:0] v; int t;} ent_t;
  ent_t q[$];
  int ts;
  logic [7:0] prev;
  bit primed, ovf;
  int drops;

  value_change_fifo dut (.clk(clk), .reset(reset), .value(value), .out_valid(out_valid),
    .out_ready(out_ready), .out_value(out_value), .out_time(out_time), .level(level),
    .overflow(overflow), .drop_count(drop_count));
  value_change_fifo #(.TS_WIDTH(4)) dut4 (.clk(clk), .reset(reset), .value(value),
    .out_valid(out_valid4), .out_ready(out_ready), .out_value(out_value4), .out_time(out_time4),
    .level(level4), .overflow(overflow4), .drop_count(drop_count4));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    ts = 0;
    prev = 0;
    primed = 0;
    ovf = 0;
    drops = 0;
  endtask

  task automatic check_all();
    bit v;
    v = q.size() > 0;
    check("valid", 32'(out_valid), 32'(v));
    check("value", 32'(out_value), v ? 32'(q[0].v) : 0);
    check("time", 32'(out_time), v ? 32'(q[0].t % 65536) : 0);
    check("level", 32'(level), 32'(q.size()));
    check("overflow", 32'(overflow), 32'(ovf));
    check("drops", 32'(drop_count), 32'(drops));
    check("valid4", 32'(out_valid4), 32'(v));
    check("value4", 32'(out_value4), v ? 32'(q[0].v) : 0);
    check("time4", 32'(out_time4), v ? 32'(q[0].t % 16) : 0);
  endtask

  // Applies the behavioural rules for the coming edge, then advances one clock.
  task automatic step();
    bit pop, change;
    pop = q.size() > 0 && out_ready;
    change = !primed || value != prev;
    if (pop) void'(q.pop_front());
    if (change) begin
      if (q.size() < 4) q.push_back('{value, ts});
      else begin
        ovf = 1;
        if (drops < 255) drops++;
      end
    end
    prev = value;
    primed = 1;
    ts++;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n, input int p_change, input int p_ready);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(99) < p_change) value = 8'($urandom);
      out_ready = $urandom_range(99) < p_ready;
      step();
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_all();
    value = 8'h00;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    for (int i = 1; i <= 20; i++) begin
      value = 8'(i);
      step();
    end
    run(200, 50, 70);
    run(280, 100, 0);
    run(40, 30, 100);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      value = value + 8'd1;
      step();
    end
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 reset = 1'b0;
    value = 8'h07;
    out_ready = 1'b0;
    step();
    run(12, 100, 0);
    out_ready = 1'b1;
    value = 8'h03;
    for (int i = 0; i < 10; i++) step();
    value = 8'h04;
    step();
    run(300, 40, 50);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
